// File: rtl/scale_offset_decoder.sv
// Decodes b = a*C + D back to a with a multicycle restoring divider.
// Flags codewords that underflow, leave a remainder or overflow WIDTH bits.
module scale_offset_decoder #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned C     = 4,
  parameter int unsigned D     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH+1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH+1:0] out_rem,
  output logic             out_err
);

  localparam int unsigned N     = WIDTH + 2;
  localparam int unsigned CNT_W = $clog2(N);
  localparam logic [N-1:0]     C_W  = N'(C);
  localparam logic [N-1:0]     D_W  = N'(D);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {IDLE, SUB, DIV, DONE} state_t;

  state_t           state;
  state_t           state_nx;
  logic [N-1:0]     b_reg;
  logic [N-1:0]     dvd;
  logic [N-1:0]     rem;
  logic [N-1:0]     dvd_nx;
  logic [N-1:0]     rem_nx;
  logic [N:0]       trial;
  logic             ge;
  logic             sub_fail;
  logic             last;
  logic [CNT_W-1:0] cnt;

  // Dividend shifts out MSB-first while quotient bits shift in at the LSB,
  // so after N steps dvd holds the full quotient.
  always_comb begin
    trial  = {rem, dvd[N-1]};
    ge     = (trial >= {1'b0, C_W});
    rem_nx = ge ? N'(trial - {1'b0, C_W}) : trial[N-1:0];
    dvd_nx = {dvd[N-2:0], ge};
  end

  assign sub_fail  = (b_reg < D_W) || (C_W == '0);
  assign last      = (cnt == LAST);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid) state_nx = SUB;
      SUB:     state_nx = sub_fail ? DONE : DIV;
      DIV:     if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_reg   <= '0;
      dvd     <= '0;
      rem     <= '0;
      cnt     <= '0;
      out_a   <= '0;
      out_rem <= '0;
      out_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) b_reg <= in_b;
        SUB: begin
          if (sub_fail) begin
            out_a   <= '0;
            out_rem <= '0;
            out_err <= 1'b1;
          end else begin
            dvd <= b_reg - D_W;
            rem <= '0;
            cnt <= '0;
          end
        end
        DIV: begin
          dvd <= dvd_nx;
          rem <= rem_nx;
          if (last) begin
            cnt     <= '0;
            out_a   <= dvd_nx[WIDTH-1:0];
            out_rem <= rem_nx;
            out_err <= (rem_nx != '0) || (dvd_nx[N-1:WIDTH] != '0);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scale_offset_decoder.sv
// Scoreboard bench: stimulus pushes expected results, monitors pop and compare
// whenever a decoder presents out_valid.
module tb_scale_offset_decoder;

  localparam int unsigned W = 4;
  localparam int unsigned N = W + 2;

  typedef struct {
    int unsigned a;
    int unsigned rem;
    int unsigned err;
    int unsigned lat;
    int unsigned acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [N-1:0] in_b, out_rem;
  logic [W-1:0] out_a;
  logic         out_err;
  logic         in_valid1, in_ready1, out_valid1, out_ready1;
  logic [N-1:0] in_b1, out_rem1;
  logic [W-1:0] out_a1;
  logic         out_err1;

  exp_t        sb0[$];
  exp_t        sb1[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned rdy_mode = 0;

  scale_offset_decoder #(.WIDTH(W), .C(4), .D(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_rem(out_rem), .out_err(out_err)
  );

  scale_offset_decoder #(.WIDTH(W), .C(1), .D(0)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_b(in_b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_a(out_a1), .out_rem(out_rem1), .out_err(out_err1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: decode straight from b = a*C + D with integer division.
  function automatic exp_t model(int unsigned b, int unsigned c, int unsigned d,
                                 int unsigned acc);
    exp_t e;
    int unsigned cm = c % (1 << N);
    int unsigned dm = d % (1 << N);
    int unsigned q;
    e.acc = acc;
    if (b < dm || cm == 0) begin
      e.a = 0; e.rem = 0; e.err = 1; e.lat = 2;
    end else begin
      q     = (b - dm) / cm;
      e.rem = (b - dm) % cm;
      e.a   = q % (1 << W);
      e.err = (e.rem != 0 || q >= (1 << W)) ? 1 : 0;
      e.lat = N + 2;
    end
    return e;
  endfunction

  task automatic check(string name, int unsigned act, int unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic send0(logic [N-1:0] b);
    int unsigned waited = 0;
    @(posedge clk); #1;
    in_b = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready) begin
      waited++;
      if (waited > 200) begin
        check("accept_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    sb0.push_back(model(32'(b), 4, 3, cyc));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send1(logic [N-1:0] b);
    int unsigned waited = 0;
    @(posedge clk); #1;
    in_b1 = b;
    in_valid1 = 1'b1;
    @(negedge clk);
    while (!in_ready1) begin
      waited++;
      if (waited > 200) begin
        check("c1_accept_timeout", 0, 1);
        in_valid1 = 1'b0;
        return;
      end
      @(negedge clk);
    end
    sb1.push_back(model(32'(b), 1, 0, cyc));
    @(posedge clk); #1;
    in_valid1 = 1'b0;
  endtask

  task automatic drain0();
    int unsigned waited = 0;
    @(negedge clk);
    while (sb0.size() != 0 || !in_ready) begin
      waited++;
      if (waited > 300) begin
        check("drain_timeout", 0, 1);
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = ($urandom_range(0, 2) != 0);
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor for the default instance: expected values on the first DONE cycle,
  // stability while stalled, and return to IDLE with retained outputs.
  logic         pv0 = 1'b0, post0 = 1'b0;
  logic [W-1:0] pa0;
  logic [N-1:0] pr0;
  logic         pe0;
  exp_t         e0;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        pv0 = 1'b0;
        post0 = 1'b0;
      end else begin
        if (post0) begin
          check("ready_after_done", 32'(in_ready), 1);
          check("valid_drop", 32'(out_valid), 0);
          check("retain_a", 32'(out_a), 32'(pa0));
          post0 = 1'b0;
        end
        if (pv0 && !out_valid) check("valid_held", 0, 1);
        if (out_valid) begin
          check("ready_in_done", 32'(in_ready), 0);
          if (pv0) begin
            check("hold_a", 32'(out_a), 32'(pa0));
            check("hold_rem", 32'(out_rem), 32'(pr0));
            check("hold_err", 32'(out_err), 32'(pe0));
          end else if (sb0.size() == 0) begin
            check("unexpected_valid", 1, 0);
          end else begin
            e0 = sb0.pop_front();
            check("latency", cyc - e0.acc, e0.lat);
            check("out_a", 32'(out_a), e0.a);
            check("out_rem", 32'(out_rem), e0.rem);
            check("out_err", 32'(out_err), e0.err);
          end
          post0 = out_ready;
        end
        pv0 = out_valid && !out_ready;
        pa0 = out_a;
        pr0 = out_rem;
        pe0 = out_err;
      end
    end
  end

  exp_t e1;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && out_valid1) begin
        if (sb1.size() == 0) begin
          check("c1_unexpected_valid", 1, 0);
        end else begin
          e1 = sb1.pop_front();
          check("c1_latency", cyc - e1.acc, e1.lat);
          check("c1_out_a", 32'(out_a1), e1.a);
          check("c1_out_rem", 32'(out_rem1), e1.rem);
          check("c1_out_err", 32'(out_err1), e1.err);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned dir[8] = '{23, 63, 24, 2, 0, 3, 4, 62};
    reset = 1'b1;
    in_valid = 1'b0; in_b = '0;
    in_valid1 = 1'b0; in_b1 = '0; out_ready1 = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_ready", 32'(in_ready), 1);
    check("rst_a", 32'(out_a), 0);
    check("rst_rem", 32'(out_rem), 0);
    check("rst_err", 32'(out_err), 0);
    reset = 1'b0;

    rdy_mode = 1;
    foreach (dir[i]) send0(N'(dir[i]));
    drain0();

    rdy_mode = 0;
    repeat (40) send0(N'($urandom_range(0, 63)));
    drain0();

    // Stall in DONE while pulsing in_valid; none of these may be accepted.
    rdy_mode = 2;
    send0(N'(23));
    begin
      int unsigned waited = 0;
      @(negedge clk);
      while (!out_valid && waited < 50) begin
        waited++;
        @(negedge clk);
      end
      check("hold_reach_done", 32'(out_valid), 1);
    end
    repeat (6) begin
      @(posedge clk); #1;
      in_valid = ~in_valid;
      in_b = N'($urandom_range(0, 63));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rdy_mode = 1;
    drain0();

    send1(N'(20));
    send1(N'(5));
    send1(N'(63));
    repeat (10) @(negedge clk);
    check("c1_drained", sb1.size(), 0);

    // Reset in the middle of DIV discards the transaction.
    send0(N'(63));
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_a", 32'(out_a), 0);
    check("midrst_rem", 32'(out_rem), 0);
    check("midrst_err", 32'(out_err), 0);
    check("midrst_ready", 32'(in_ready), 1);
    sb0.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    send0(N'(7));
    drain0();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scale_offset_decoder.md
SCALE_OFFSET_DECODER -- requirements
Module: scale_offset_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 4: width of the recovered operand a.
REQ-002 SHALL have parameter C, default 4: scale factor of the encoding b = a*C + D; unsigned integer.
REQ-003 SHALL have parameter D, default 3: offset of the encoding; unsigned integer.
REQ-004 SHALL have port clk  input  1: the only clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1: in_b is valid.
REQ-007 SHALL have port in_ready  output  1: the block accepts in_b this cycle.
REQ-008 SHALL have port in_b  input  WIDTH+2: encoded word to decode.
REQ-009 SHALL have port out_valid  output  1: the result is valid.
REQ-010 SHALL have port out_ready  input  1: the consumer accepts the result.
REQ-011 SHALL have port out_a  output  WIDTH: decoded operand, (in_b-D)/C truncated to WIDTH bits.
REQ-012 SHALL have port out_rem  output  WIDTH+2: remainder (in_b-D) mod C.
REQ-013 SHALL have port out_err  output  1: in_b is not a legal codeword.

Function
REQ-014 SHALL implement a four-state FSM: IDLE, SUB, DIV, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; both SHALL be registered or state-decoded, with no combinational path from inputs.
REQ-016 Accept: in IDLE with in_valid=1 (cycle T), SHALL capture in_b and move to SUB.
REQ-017 SUB (cycle T+1): SHALL compute diff = in_b - D at WIDTH+2 bits.
REQ-018 SUB, underflow (in_b < D) or C == 0: SHALL set out_err=1, out_a=0, out_rem=0, and go to DONE; out_valid SHALL be 1 at T+2.
REQ-019 SUB, otherwise: SHALL load the restoring-divider state and go to DIV.
REQ-020 DIV SHALL take one quotient bit per cycle, MSB first, for exactly N = WIDTH+2 cycles, using an iteration counter that wraps to 0 on exit.
REQ-021 After the last DIV cycle, SHALL go to DONE; out_valid SHALL be 1 at T+N+2 (T+8 for WIDTH=4).
REQ-022 Result: quotient q is WIDTH+2 bits; out_a = q[WIDTH-1:0] and out_rem = the final partial remainder.
REQ-023 out_err SHALL be 1 if underflow, or C == 0, or out_rem != 0, or q >= 2^WIDTH (overflow, reported with the truncated out_a).
REQ-024 DONE: SHALL hold all outputs stable while out_ready=0; with out_ready=1, SHALL go to IDLE on the next edge.
REQ-025 SHALL process at most one transaction at a time; in_valid SHALL be ignored outside IDLE.
REQ-026 out_a, out_rem and out_err SHALL retain the last result after leaving DONE, until the next result is written.
REQ-027 Arithmetic SHALL be unsigned, with C and D constants resized to WIDTH+2 bits.

Reset
REQ-028 reset=1 SHALL asynchronously force IDLE, counter=0, out_valid=0, out_a=0, out_rem=0, out_err=0, and in_ready=1 on the first edge after release.
REQ-029 reset asserted mid-DIV or in DONE SHALL discard the transaction; no out_valid SHALL follow until a new accept.

Verification (WIDTH=4, C=4, D=3 unless stated)
REQ-030 in_b=23 accepted at T, out_ready=1 -> out_valid at T+8 with out_a=5, out_rem=0, out_err=0; in_ready=1 at T+9.
REQ-031 in_b=63 -> out_a=15, out_rem=0, out_err=0; in_b=24 -> out_a=5, out_rem=1, out_err=1.
REQ-032 in_b=2 (underflow) -> out_valid at T+2, out_err=1, out_a=0, out_rem=0.
REQ-033 C=1, D=0, in_b=20 -> q=20 overflows, out_a=4, out_err=1.
REQ-034 out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0, and in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-035 reset pulsed at T+4 during DIV -> all outputs 0 at once, no out_valid afterwards; a fresh in_b=7 then yields out_a=1, out_err=0 at accept+8.
